cbus_arbiter: RTL
=================

# cbus_arbiter

Round-robin arbiter that shares the single cache-bus (cbus) master port between the instruction-cache refill path and the data-cache refill/writeback path behind the MMU. It grants one requester at a time, holds the grant for the full burst, and returns the bus only after the final beat. Responses are steered to the owner only, and a beat counter cross-checks burst length against the `last` indication.

## Interface
- `NUM_REQ`, default 2 — number of requesters; index 0 = DCache, 1 = ICache.
- `IDX_W`, default `$clog2(NUM_REQ)` — grant index width.
- `clk`  input  1  — single clock; all state updates on its rising edge.
- `reset`  input  1  — synchronous, active-high reset.
- `ireqs`  input  `cbus_req_t [NUM_REQ]`  — requester buses (fields valid, is_write, size, addr, strobe, data, len).
- `iresps`  output  `cbus_resp_t [NUM_REQ]`  — per-requester response (ready, last, data).
- `oreq`  output  `cbus_req_t`  — request to the shared bus/AXI bridge.
- `oresp`  input  `cbus_resp_t`  — shared bus response.
- `busy`  output  1  — a grant is held.
- `grant_idx`  output  `IDX_W`  — current/last owner index.
- `len_err`  output  1  — sticky: a burst ended with a beat count different from `len+1`.

## Operation
- Two states: IDLE, BUSY.
- IDLE:
  - `oreq` is all-zero.
  - All `iresps` are zero.
  - If any `ireqs[i].valid` is high, pick the first valid index searching upward, wrapping, starting at `last_grant+1 mod NUM_REQ`.
  - Register it into `grant_idx`, clear `beat_cnt`, and go to BUSY.
- BUSY:
  - `oreq = ireqs[grant_idx]`, passed live so per-beat write data and strobe flow through.
  - `iresps[grant_idx] = oresp`; every other `iresps` entry is all-zero.
  - `beat_cnt` increments on each `oresp.ready`, saturating at 8 bits.
  - On `oresp.ready && oresp.last`:
    - Set `last_grant <= grant_idx` and return to IDLE.
    - If `beat_cnt+1 != len+1`, set `len_err`.
- If the owner drops `valid` mid-burst, that is a protocol violation. The arbiter does not release the bus and stays in BUSY forwarding the (invalid) request until `last`.
- Non-owner requests stay pending. Their `ready` stays 0, so each requester holds its request.
- `len_err` is cleared only by reset.
- `len` is AXI-style (beats − 1). Compare it at width 8, zero-extended.

## Timing
- Reset values:
  - State = IDLE, `busy = 0`, `grant_idx = 0`.
  - `last_grant = NUM_REQ-1`, so index 0 wins first.
  - `beat_cnt = 0`, `len_err = 0`, `oreq = 0`, `iresps = 0`.
- Grant latency: valid sampled in IDLE at edge t; `oreq.valid` is high during cycle t+1.
- Minimum one IDLE cycle between bursts. After `last` at edge t, the bus is idle for cycle t+1. The next owner drives `oreq` from t+2.
- `busy` is a registered flag equal to (state == BUSY).
- Response path `oresp`→`iresps` is purely combinational; no added latency.
- Single-beat burst (`len = 0`): `ready` and `last` in the same cycle end the transaction normally.
- Reset asserted mid-burst: next cycle the block is IDLE with `oreq` zero and the burst abandoned. The downstream bridge is reset by the same signal.
- Simultaneous requests in IDLE: resolved by round-robin, never both granted.
- The owner re-requesting the cycle it finishes competes normally. If another requester is waiting, that requester wins.

## Test plan
- Reset with `ireqs[0].valid = 1` held through reset → all outputs 0 during reset. First cycle after: IDLE. Second cycle: `busy = 1`, `grant_idx = 0`, `oreq.addr = ireqs[0].addr`.
- DCache 4-beat read (`len = 3`) with `oresp.ready` every cycle and `last` on beat 4 → `iresps[0]` carries 4 data words. `iresps[1]` stays 0. `busy` drops one cycle after `last`. `len_err = 0`.
- Both requesters valid continuously with 2-beat bursts → grants alternate 0,1,0,1 over 4 bursts. Each grant is separated by exactly one IDLE cycle.
- ICache burst in progress; DCache asserts valid mid-burst → ICache keeps the bus to `last`. DCache is granted on the next IDLE decision. DCache `ready` stays 0 until then.
- 8-beat write (`len = 7`) with data changing per beat and `oresp.ready` toggling 1,0,1… → `oreq.data` tracks the owner every cycle. Completion occurs after 8 ready beats.
- Burst with `len = 3` where `last` arrives on beat 2 → return to IDLE and `len_err = 1` held until reset. Reset asserted during a following burst → IDLE next cycle, `len_err = 0`.

Source files
------------

// File: rtl/cbus_arbiter.sv
// Cache-bus request/response types and a round-robin arbiter that shares one
// cbus master port between the DCache (index 0) and ICache (index 1) refill paths.
package cbus_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [7:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage

module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  cbus_req_t        ireqs  [NUM_REQ],
    output cbus_resp_t       iresps [NUM_REQ],
    output cbus_req_t        oreq,
    input  cbus_resp_t       oresp,
    output logic             busy,
    output logic [IDX_W-1:0] grant_idx,
    output logic             len_err
);

    localparam logic [0:0]  ST_IDLE = 1'b0;
    localparam logic [0:0]  ST_BUSY = 1'b1;
    localparam int unsigned NREQ_U  = NUM_REQ;

    logic [0:0]       state_q, state_d;
    logic             busy_q, busy_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic [7:0]       beat_cnt_q, beat_cnt_d;
    logic             len_err_q, len_err_d;

    logic             rr_found;
    logic [IDX_W-1:0] rr_idx;

    // Search starts one past the previous owner and wraps, so an owner
    // re-requesting on its final beat loses to any waiting requester.
    always_comb begin
        int unsigned cand;
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = 0;
        for (int unsigned off = 1; off <= NREQ_U; off++) begin
            cand = (int'(last_grant_q) + off) % NREQ_U;
            if (!rr_found && ireqs[cand].valid) begin
                rr_found = 1'b1;
                rr_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        len_err_d    = len_err_q;
        oreq         = '0;
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            iresps[i] = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (rr_found) begin
                    grant_d    = rr_idx;
                    beat_cnt_d = '0;
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                oreq            = ireqs[grant_q];
                iresps[grant_q] = oresp;
                if (oresp.ready) begin
                    if (beat_cnt_q != '1) begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                    if (oresp.last) begin
                        last_grant_d = grant_q;
                        state_d      = ST_IDLE;
                        if (({1'b0, beat_cnt_q} + 9'd1) != ({1'b0, ireqs[grant_q].len} + 9'd1)) begin
                            len_err_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Bus side is quiet for the whole reset cycle, even if a burst was in flight.
        if (reset) begin
            oreq = '0;
            for (int unsigned i = 0; i < NREQ_U; i++) begin
                iresps[i] = '0;
            end
        end

        busy_d = (state_d == ST_BUSY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            beat_cnt_q   <= '0;
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            len_err_q    <= len_err_d;
        end
    end

    assign busy      = busy_q;
    assign grant_idx = grant_q;
    assign len_err   = len_err_q;

endmodule
